// File: rtl/fir_pkg.sv
// Constants and state encoding for the FIR sample sequencer.
// The coefficient ROM and fir_core use the same constants.
package fir_pkg;
    localparam int DATA_W   = 16;
    localparam int NUM_TAPS = 317;
    localparam int ADDR_W   = 9;
    localparam int PIPE_LAT = 4;
    localparam int DRAIN_W  = $clog2(PIPE_LAT + 1);

    localparam logic [2:0] ST_CLEAR = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_MAC   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
endpackage

// File: rtl/fir_tap_pipe.sv
// Delay line of DEPTH stages that carries the {valid, first} strobes.
// Its timing matches the operand read latency of the MAC datapath.
module fir_tap_pipe #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_in,
    input  logic first_in,
    output logic valid_out,
    output logic first_out
);
    logic [DEPTH-1:0] valid_sr;
    logic [DEPTH-1:0] first_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_sr <= '0;
            first_sr <= '0;
        end else begin
            valid_sr <= (valid_sr << 1) | DEPTH'(valid_in);
            first_sr <= (first_sr << 1) | DEPTH'(first_in);
        end
    end

    assign valid_out = valid_sr[DEPTH-1];
    assign first_out = first_sr[DEPTH-1];
endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequencer for one FIR output. It writes each new sample into the circular
// sample memory, then walks every tap, newest sample first.
module fir_mac_sequencer
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              ovr_clr,
    output logic              smp_we,
    output logic [ADDR_W-1:0] smp_waddr,
    output logic [DATA_W-1:0] smp_wdata,
    output logic              rd_en,
    output logic [ADDR_W-1:0] smp_raddr,
    output logic [ADDR_W-1:0] coeff_addr,
    output logic              mac_valid,
    output logic              mac_first,
    output logic              out_strobe,
    output logic              busy,
    output logic              overrun
);
    localparam logic [ADDR_W-1:0]  LAST_TAP   = ADDR_W'(NUM_TAPS - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(PIPE_LAT - 1);

    logic [2:0]         state;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               drop;

    assign drop = in_valid && !in_ready;

    // `state` names the phase that the registered outputs show in the current cycle.
    // Each edge loads the outputs of the next phase.
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_CLEAR;
            wr_ptr     <= '0;
            drain_cnt  <= '0;
            in_ready   <= 1'b0;
            smp_we     <= 1'b0;
            smp_waddr  <= '0;
            smp_wdata  <= '0;
            rd_en      <= 1'b0;
            smp_raddr  <= '0;
            coeff_addr <= '0;
            out_strobe <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (drop)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;

            case (state)
                // NOTE: reset does not touch the sample memory; this sweep zeroes it instead.
                ST_CLEAR: begin
                    if (smp_we && smp_waddr == LAST_TAP) begin
                        state    <= ST_IDLE;
                        smp_we   <= 1'b0;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end else begin
                        smp_we    <= 1'b1;
                        smp_waddr <= smp_we ? smp_waddr + ADDR_W'(1) : '0;
                        smp_wdata <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (in_valid) begin
                        state     <= ST_WRITE;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        smp_we    <= 1'b1;
                        smp_waddr <= wr_ptr;
                        smp_wdata <= in_data;
                    end
                end
                ST_WRITE: begin
                    state      <= ST_MAC;
                    smp_we     <= 1'b0;
                    rd_en      <= 1'b1;
                    coeff_addr <= '0;
                    smp_raddr  <= wr_ptr;
                end
                ST_MAC: begin
                    if (coeff_addr == LAST_TAP) begin
                        state     <= ST_DRAIN;
                        rd_en     <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        coeff_addr <= coeff_addr + ADDR_W'(1);
                        smp_raddr  <= (smp_raddr == '0) ? LAST_TAP : smp_raddr - ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        state      <= ST_DONE;
                        out_strobe <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    out_strobe <= 1'b0;
                    busy       <= 1'b0;
                    in_ready   <= 1'b1;
                    wr_ptr     <= (wr_ptr == LAST_TAP) ? '0 : wr_ptr + ADDR_W'(1);
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    fir_tap_pipe #(
        .DEPTH(PIPE_LAT)
    ) u_tap_pipe (
        .clk      (clk),
        .rst_n    (rst),
        .valid_in (rd_en),
        .first_in (rd_en && coeff_addr == '0),
        .valid_out(mac_valid),
        .first_out(mac_first)
    );
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed and randomised bench for fir_mac_sequencer. A cycle-indexed model
// of one frame supplies the expected value of every output in every cycle.
module tb_fir_mac_sequencer;
    import fir_pkg::*;

    localparam int FRAME_LEN = NUM_TAPS + PIPE_LAT + 3;

    typedef struct packed {
        logic              in_ready;
        logic              busy;
        logic              smp_we;
        logic              rd_en;
        logic              mac_valid;
        logic              mac_first;
        logic              out_strobe;
        logic              overrun;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [ADDR_W-1:0] raddr;
        logic [ADDR_W-1:0] coeff;
    } snap_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              ovr_clr = 1'b0;
    logic              in_ready, smp_we, rd_en, mac_valid, mac_first, out_strobe, busy, overrun;
    logic [ADDR_W-1:0] smp_waddr, smp_raddr, coeff_addr;
    logic [DATA_W-1:0] smp_wdata;

    int n_checks = 0;
    int n_err    = 0;
    int wp       = 0;
    bit exp_ovr  = 1'b0;

    always #5 clk = ~clk;

    fir_mac_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ovr_clr(ovr_clr), .smp_we(smp_we), .smp_waddr(smp_waddr), .smp_wdata(smp_wdata),
        .rd_en(rd_en), .smp_raddr(smp_raddr), .coeff_addr(coeff_addr), .mac_valid(mac_valid),
        .mac_first(mac_first), .out_strobe(out_strobe), .busy(busy), .overrun(overrun)
    );

    // Address and data fields are compared only while their enable is expected.
    // With raw set, every output is compared in full.
    function automatic snap_t observe(input snap_t e, input bit raw);
        snap_t o;
        o = '{in_ready, busy, smp_we, rd_en, mac_valid, mac_first, out_strobe, overrun,
              smp_waddr, smp_wdata, smp_raddr, coeff_addr};
        if (!raw && !e.smp_we) begin o.waddr = '0; o.wdata = '0; end
        if (!raw && !e.rd_en)  begin o.raddr = '0; o.coeff = '0; end
        return o;
    endfunction

    task automatic check(input string tag, input int cyc, input snap_t e, input bit raw);
        snap_t o;
        o = observe(e, raw);
        n_checks++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
        end
    endtask

    // Expected outputs in cycle c of a frame; the sample is accepted at the end of cycle 0.
    function automatic snap_t frame_exp(input int c, input logic [DATA_W-1:0] s, input int p, input bit ovr);
        snap_t e;
        int k;
        e = '0;
        e.in_ready   = (c == 0) || (c == FRAME_LEN);
        e.busy       = (c >= 1) && (c <= FRAME_LEN - 1);
        e.smp_we     = (c == 1);
        if (e.smp_we) begin e.waddr = ADDR_W'(p); e.wdata = s; end
        e.rd_en      = (c >= 2) && (c <= NUM_TAPS + 1);
        if (e.rd_en) begin
            k       = c - 2;
            e.coeff = ADDR_W'(k);
            e.raddr = ADDR_W'((p - k + NUM_TAPS) % NUM_TAPS);
        end
        e.mac_valid  = (c >= 2 + PIPE_LAT) && (c <= NUM_TAPS + 1 + PIPE_LAT);
        e.mac_first  = (c == 2 + PIPE_LAT);
        e.out_strobe = (c == NUM_TAPS + 2 + PIPE_LAT);
        e.overrun    = ovr;
        return e;
    endfunction

    // Entered just after rst rises on a falling edge. Returns in the first IDLE cycle.
    task automatic check_clear();
        snap_t e;
        in_valid = 1'b0;
        for (int c = 1; c <= NUM_TAPS + 1; c++) begin
            @(negedge clk);
            e = '0;
            if (c <= NUM_TAPS) begin
                e.smp_we = 1'b1;
                e.busy   = 1'b1;
                e.waddr  = ADDR_W'(c - 1);
            end else begin
                e.in_ready = 1'b1;
            end
            e.overrun = exp_ovr;
            check("clear", c, e, 1'b0);
        end
    endtask

    task automatic idle(input int n, input bit clr_first);
        snap_t e;
        for (int i = 0; i < n; i++) begin
            e = '0;
            e.in_ready = 1'b1;
            e.overrun  = exp_ovr;
            check("idle", i, e, 1'b0);
            in_valid = 1'b0;
            ovr_clr  = clr_first && (i == 0);
            if (ovr_clr) exp_ovr = 1'b0;
            @(negedge clk);
        end
        ovr_clr = 1'b0;
    endtask

    // Entered in cycle 0 with in_ready expected high.
    // abort >= 0 pulls rst low after that cycle has been checked.
    task automatic run_frame(input logic [DATA_W-1:0] s, input bit hold, input int poke1, input int poke2,
                             input int clr1, input int clr2, input int abort);
        snap_t e;
        bit    next_ovr;
        for (int c = 0; c <= FRAME_LEN; c++) begin
            e = frame_exp(c, s, wp, exp_ovr);
            check("frame", c, e, 1'b0);
            if (c == FRAME_LEN) break;
            if (c == abort) begin
                rst = 1'b0; in_valid = 1'b0; ovr_clr = 1'b0;
                #1 check("reset_async", c, '0, 1'b1);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("reset_hold", i, '0, 1'b1);
                end
                rst = 1'b1;
                wp = 0;
                exp_ovr = 1'b0;
                return;
            end
            in_valid = (c == 0) || hold || (c == poke1) || (c == poke2);
            ovr_clr  = (c == clr1) || (c == clr2);
            in_data  = (c == 0) ? s : DATA_W'($urandom);
            next_ovr = (in_valid && !e.in_ready) ? 1'b1 : (ovr_clr ? 1'b0 : exp_ovr);
            @(negedge clk);
            exp_ovr = next_ovr;
        end
        ovr_clr = 1'b0;
        wp = (wp + 1) % NUM_TAPS;
    endtask

    initial begin
        #2 rst = 1'b0;
        #1 check("reset_init", 0, '0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_clear();

        run_frame(16'h4000, 1'b0, -1, -1, -1, -1, -1);
        run_frame(DATA_W'($urandom), 1'b0, -1, -1, -1, -1, -1);
        // A dropped offer sets overrun; a clear alone resets it; set and clear together leaves it set.
        run_frame(DATA_W'($urandom), 1'b0, 100, 200, 150, 200, -1);
        idle(3, 1'b1);
        for (int f = 0; f < 3; f++) begin
            run_frame(DATA_W'($urandom), 1'b0, -1, -1, -1, -1, -1);
            idle(int'($urandom_range(1, 5)), 1'b0);
        end

        // Reset during MAC tap 150 abandons the frame.
        run_frame(DATA_W'($urandom), 1'b0, -1, -1, -1, -1, 152);
        check_clear();

        for (int f = 0; f < 3; f++)
            run_frame(DATA_W'($urandom), 1'b1, -1, -1, -1, -1, -1);
        idle(4, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule
